// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the VGA raster timing block:
//   - default 640x480 @ 60 Hz timing constants
//   - helpers that derive the full line/frame lengths from the four segments
//   - sync_bundle_t, the {visible, hs, vs} group carried through the delay line
// Sync bits in the bundle are raw "active" flags; polarity is applied only at
// the very output, so the idle bundle is all zeros.
package vga_timing_pkg;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int COORD_W = 12;

    function automatic int calc_h_total(int display, int front, int sync, int back);
        return display + front + sync + back;
    endfunction

    function automatic int calc_v_total(int display, int front, int sync, int back);
        return display + front + sync + back;
    endfunction

    typedef struct packed {
        logic visible;
        logic hs;
        logic vs;
    } sync_bundle_t;

    localparam sync_bundle_t SYNC_IDLE = '{visible: 1'b0, hs: 1'b0, vs: 1'b0};

endpackage

// File: rtl/vga_timing_gen_delay.sv
// vga_sync_delay
// Fixed-depth shift register for the {visible, hs, vs} bundle, used to keep the
// sync/blank outputs aligned with registered pixel data further downstream.
// Ports:
//   vga_clk  - pixel-domain clock; the line shifts every cycle
//   rst_n    - asynchronous active-low reset, loads every stage with SYNC_IDLE
//   din      - raw bundle decoded from the current counters
//   dout     - bundle delayed by DEPTH cycles (combinational pass-through if 0)
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         vga_clk,
    input  logic         rst_n,
    input  sync_bundle_t din,
    output sync_bundle_t dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_pipe
            sync_bundle_t stages [DEPTH];

            // Stage 0 captures the raw decode; each later stage takes its neighbour.
            always_ff @(posedge vga_clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= SYNC_IDLE;
                    end
                end else begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster-scan generator for the Tetris display. Runs free column/row counters
// gated by a pixel tick, decodes visible/hsync/vsync, delays those through
// vga_sync_delay, and produces undelayed frame/vblank strobes plus a frame count.
// Ports:
//   vga_clk      - pixel-domain clock
//   rst_n        - asynchronous active-low reset
//   pix_en       - pixel tick; counters advance only when high
//   vga_row      - current row, 0..V_TOTAL-1
//   vga_col      - current column, 0..H_TOTAL-1
//   video_on     - visible-area flag, delayed PIPE_DELAY cycles
//   hsync/vsync  - sync pulses, delayed PIPE_DELAY cycles, polarity per SYNC_ACTIVE_LOW
//   frame_start  - one-cycle pulse when the counters wrap to (0,0)
//   vblank_start - one-cycle pulse when the counters reach (V_DISPLAY,0)
//   frame_count  - completed frames, wraps at 16 bits
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY       = DEF_H_DISPLAY,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int V_DISPLAY       = DEF_V_DISPLAY,
    parameter int V_FRONT         = DEF_V_FRONT,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BACK          = DEF_V_BACK,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int PIPE_DELAY      = 2
) (
    input  logic                vga_clk,
    input  logic                rst_n,
    input  logic                pix_en,
    output logic [COORD_W-1:0]  vga_row,
    output logic [COORD_W-1:0]  vga_col,
    output logic                video_on,
    output logic                hsync,
    output logic                vsync,
    output logic                frame_start,
    output logic                vblank_start,
    output logic [15:0]         frame_count
);

    localparam int H_TOTAL = calc_h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = calc_v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS_END  = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS_END  = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS_LAST = COORD_W'(V_DISPLAY - 1);
    localparam logic [COORD_W-1:0] HS_START   = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END     = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START   = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END     = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);

    sync_bundle_t raw_bundle;
    sync_bundle_t dly_bundle;

    // Counters and strobes. Strobes are registered on the same edge that moves
    // the counters, so they line up with the first cycle of the new position and
    // cannot repeat while pix_en holds the counters still.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_col      <= '0;
            vga_row      <= '0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else begin
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            if (pix_en) begin
                if (vga_col == H_LAST) begin
                    vga_col <= '0;
                    if (vga_row == V_LAST) begin
                        vga_row     <= '0;
                        frame_start <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        vga_row <= vga_row + 12'd1;
                        if (vga_row == V_VIS_LAST) begin
                            vblank_start <= 1'b1;
                        end
                    end
                end else begin
                    vga_col <= vga_col + 12'd1;
                end
            end
        end
    end

    // Raw decode of the current counters. Visible is qualified with rst_n so a
    // zero-depth build still shows video_on low while held in reset.
    always_comb begin
        raw_bundle         = SYNC_IDLE;
        raw_bundle.visible = rst_n && (vga_col < H_VIS_END) && (vga_row < V_VIS_END);
        raw_bundle.hs      = (vga_col >= HS_START) && (vga_col < HS_END);
        raw_bundle.vs      = (vga_row >= VS_START) && (vga_row < VS_END);
    end

    vga_sync_delay #(
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .din     (raw_bundle),
        .dout    (dly_bundle)
    );

    // Polarity goes on last so idle stages in the delay line read as inactive sync.
    assign video_on = dly_bundle.visible;
    assign hsync    = dly_bundle.hs ^ SYNC_ACTIVE_LOW;
    assign vsync    = dly_bundle.vs ^ SYNC_ACTIVE_LOW;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. Four instances share clock/reset/pix_en:
//   dut   - default 640x480 timing, PIPE_DELAY=2
//   dut0  - default timing, PIPE_DELAY=0
//   dut3  - default timing, PIPE_DELAY=3
//   dut_s - tiny 15x10 raster (PIPE_DELAY=2) so whole frames fit in a short run
// Outputs are sampled 1 ns after each rising edge; inputs change at that point too.
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic pix_en  = 1'b0;

    logic [11:0] d_row, d_col, z_row, z_col, t_row, t_col, s_row, s_col;
    logic        d_von, d_hs, d_vs, d_fs, d_vb;
    logic        z_von, z_hs, z_vs, z_fs, z_vb;
    logic        t_von, t_hs, t_vs, t_fs, t_vb;
    logic        s_von, s_hs, s_vs, s_fs, s_vb;
    logic [15:0] d_fc, z_fc, t_fc, s_fc;

    int total = 0;
    int bad   = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen #(.PIPE_DELAY(2)) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .pix_en(pix_en),
        .vga_row(d_row), .vga_col(d_col), .video_on(d_von), .hsync(d_hs), .vsync(d_vs),
        .frame_start(d_fs), .vblank_start(d_vb), .frame_count(d_fc)
    );

    vga_timing_gen #(.PIPE_DELAY(0)) dut0 (
        .vga_clk(vga_clk), .rst_n(rst_n), .pix_en(pix_en),
        .vga_row(z_row), .vga_col(z_col), .video_on(z_von), .hsync(z_hs), .vsync(z_vs),
        .frame_start(z_fs), .vblank_start(z_vb), .frame_count(z_fc)
    );

    vga_timing_gen #(.PIPE_DELAY(3)) dut3 (
        .vga_clk(vga_clk), .rst_n(rst_n), .pix_en(pix_en),
        .vga_row(t_row), .vga_col(t_col), .video_on(t_von), .hsync(t_hs), .vsync(t_vs),
        .frame_start(t_fs), .vblank_start(t_vb), .frame_count(t_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIPE_DELAY(2)
    ) dut_s (
        .vga_clk(vga_clk), .rst_n(rst_n), .pix_en(pix_en),
        .vga_row(s_row), .vga_col(s_col), .video_on(s_von), .hsync(s_hs), .vsync(s_vs),
        .frame_start(s_fs), .vblank_start(s_vb), .frame_count(s_fc)
    );

    task automatic applyStimulus(input logic rst_val, input logic pix_val);
        rst_n  = rst_val;
        pix_en = pix_val;
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        int d_fall, z_fall, t_fall, d_rise, t_rise;
        int hs_low, hs_first, s_vs_low, s_vs_first;
        int s_fs_cnt, s_fs_at, s_vb_cnt, s_vb_at, r1, r2;
        logic d_prev, z_prev, t_prev;

        // ---------------- reset state ----------------
        applyStimulus(1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("rst_row", 32'(d_row), 32'd0);
        checkOutput("rst_col", 32'(d_col), 32'd0);
        checkOutput("rst_video_on", 32'(d_von), 32'd0);
        checkOutput("rst_video_on_pd0", 32'(z_von), 32'd0);
        checkOutput("rst_hsync", 32'(d_hs), 32'd1);
        checkOutput("rst_vsync", 32'(d_vs), 32'd1);
        checkOutput("rst_frame_start", 32'(d_fs), 32'd0);
        checkOutput("rst_vblank_start", 32'(d_vb), 32'd0);
        checkOutput("rst_frame_count", 32'(d_fc), 32'd0);

        // ---------------- one full line, pix_en high ----------------
        applyStimulus(1'b1, 1'b1);
        #1;
        checkOutput("pd0_video_on_at_origin", 32'(z_von), 32'd1);
        d_fall = -1; z_fall = -1; t_fall = -1; d_rise = -1; t_rise = -1;
        hs_low = 0; hs_first = -1; s_vs_low = 0; s_vs_first = -1;
        s_fs_cnt = 0; s_fs_at = -1; s_vb_cnt = 0; s_vb_at = -1;
        d_prev = d_von; z_prev = z_von; t_prev = t_von;
        for (int n = 1; n <= 800; n++) begin
            tick();
            if (d_von && !d_prev && d_rise < 0) d_rise = n;
            if (t_von && !t_prev && t_rise < 0) t_rise = n;
            if (!d_von && d_prev && d_fall < 0) d_fall = n;
            if (!z_von && z_prev && z_fall < 0) z_fall = n;
            if (!t_von && t_prev && t_fall < 0) t_fall = n;
            d_prev = d_von; z_prev = z_von; t_prev = t_von;
            if (!d_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = n;
            end
            if (n <= 150) begin
                if (!s_vs) begin
                    s_vs_low++;
                    if (s_vs_first < 0) s_vs_first = n;
                end
                if (s_fs) begin s_fs_cnt++; s_fs_at = n; end
                if (s_vb) begin s_vb_cnt++; s_vb_at = n; end
            end
            if (n == 1)   checkOutput("col_first_step", 32'(d_col), 32'd1);
            if (n == 149) checkOutput("small_fc_before_wrap", 32'(s_fc), 32'd0);
            if (n == 150) checkOutput("small_fc_after_wrap", 32'(s_fc), 32'd1);
            if (n == 799) checkOutput("col_799", 32'(d_col), 32'd799);
            if (n == 799) checkOutput("row_before_wrap", 32'(d_row), 32'd0);
        end
        checkOutput("col_wrap", 32'(d_col), 32'd0);
        checkOutput("row_after_line", 32'(d_row), 32'd1);
        checkOutput("hsync_low_cycles", 32'(hs_low), 32'd96);
        checkOutput("hsync_first_low", 32'(hs_first), 32'd658);
        checkOutput("video_rise_pd2", 32'(d_rise), 32'd2);
        checkOutput("video_rise_pd3", 32'(t_rise), 32'd3);
        checkOutput("video_fall_pd2", 32'(d_fall), 32'd642);
        checkOutput("video_fall_pd0", 32'(z_fall), 32'd640);
        checkOutput("video_fall_pd3", 32'(t_fall), 32'd643);
        checkOutput("small_vsync_low_cycles", 32'(s_vs_low), 32'd30);
        checkOutput("small_vsync_first_low", 32'(s_vs_first), 32'd107);
        checkOutput("small_frame_start_count", 32'(s_fs_cnt), 32'd1);
        checkOutput("small_frame_start_at", 32'(s_fs_at), 32'd150);
        checkOutput("small_vblank_count", 32'(s_vb_cnt), 32'd1);
        checkOutput("small_vblank_at", 32'(s_vb_at), 32'd90);

        // ---------------- mid-scan asynchronous reset ----------------
        repeat (690) tick();
        checkOutput("pre_rst_col", 32'(d_col), 32'd690);
        checkOutput("pre_rst_row", 32'(d_row), 32'd1);
        checkOutput("pre_rst_hsync_active", 32'(d_hs), 32'd0);
        checkOutput("pre_rst_small_row", 32'(s_row), 32'd9);
        checkOutput("pre_rst_small_fc", 32'(s_fc), 32'd9);
        applyStimulus(1'b0, 1'b1);
        #1;
        checkOutput("async_rst_col", 32'(d_col), 32'd0);
        checkOutput("async_rst_row", 32'(d_row), 32'd0);
        checkOutput("async_rst_hsync", 32'(d_hs), 32'd1);
        checkOutput("async_rst_vsync", 32'(d_vs), 32'd1);
        checkOutput("async_rst_video_on", 32'(d_von), 32'd0);
        checkOutput("async_rst_small_row", 32'(s_row), 32'd0);
        checkOutput("async_rst_small_fc", 32'(s_fc), 32'd0);
        repeat (2) tick();

        // ---------------- pix_en one cycle in four ----------------
        applyStimulus(1'b1, 1'b1);
        d_fall = -1; z_fall = -1; t_fall = -1;
        hs_low = 0; hs_first = -1; r1 = -1; r2 = -1;
        s_fs_cnt = 0; s_fs_at = -1; s_vb_cnt = 0; s_vb_at = -1;
        d_prev = d_von; z_prev = z_von; t_prev = t_von;
        for (int m = 1; m <= 6400; m++) begin
            tick();
            if (!d_von && d_prev && d_fall < 0) d_fall = m;
            if (!z_von && z_prev && z_fall < 0) z_fall = m;
            if (!t_von && t_prev && t_fall < 0) t_fall = m;
            d_prev = d_von; z_prev = z_von; t_prev = t_von;
            if (m <= 3200 && !d_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = m;
            end
            if (d_row == 12'd1 && r1 < 0) r1 = m;
            if (d_row == 12'd2 && r2 < 0) r2 = m;
            if (m <= 600) begin
                if (s_fs) begin s_fs_cnt++; s_fs_at = m; end
                if (s_vb) begin s_vb_cnt++; s_vb_at = m; end
            end
            if (m == 1) checkOutput("slow_restart_col", 32'(d_col), 32'd1);
            if (m == 4) checkOutput("slow_hold_col", 32'(d_col), 32'd1);
            if (m == 5) checkOutput("slow_step_col", 32'(d_col), 32'd2);
            pix_en = (m % 4 == 0);
        end
        checkOutput("slow_row1_at", 32'(r1), 32'd3197);
        checkOutput("slow_line_period", 32'(r2 - r1), 32'd3200);
        checkOutput("slow_hsync_low_cycles", 32'(hs_low), 32'd384);
        checkOutput("slow_hsync_first_low", 32'(hs_first), 32'd2623);
        checkOutput("slow_video_fall_pd2", 32'(d_fall), 32'd2559);
        checkOutput("slow_video_fall_pd0", 32'(z_fall), 32'd2557);
        checkOutput("slow_video_fall_pd3", 32'(t_fall), 32'd2560);
        checkOutput("slow_small_frame_start_count", 32'(s_fs_cnt), 32'd1);
        checkOutput("slow_small_frame_start_at", 32'(s_fs_at), 32'd597);
        checkOutput("slow_small_vblank_count", 32'(s_vb_cnt), 32'd1);
        checkOutput("slow_small_vblank_at", 32'(s_vb_at), 32'd357);

        // ---------------- frame_count wrap from 0xFFFF ----------------
        applyStimulus(1'b1, 1'b1);
        force dut_s.frame_count = 16'hFFFF;
        tick();
        release dut_s.frame_count;
        #1;
        checkOutput("preload_fc", 32'(s_fc), 32'hFFFF);
        s_fs_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (s_fs) s_fs_cnt++;
        end
        checkOutput("wrap_frame_start_count", 32'(s_fs_cnt), 32'd1);
        checkOutput("wrap_fc", 32'(s_fc), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
